// File: rtl/fpmul_norm_round.sv
// Normalize, round-to-nearest-even and pack stage of the binary32 multiplier.
// Latency: ACK rises 3 edges after the edge that captures REQ; Z/EXC are valid with it.
// Backpressure: four-phase REQ/ACK; ACK holds while REQ stays high and drops once REQ=0 is sampled.
module fpmul_norm_round (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        REQ,
   input  logic [47:0] PROD,
   input  logic [9:0]  EXP_IN,
   input  logic        SIGN_IN,
   output logic        ACK,
   output logic [31:0] Z,
   output logic [2:0]  EXC
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      NORM  = 3'd1,
      ROUND = 3'd2,
      PACK  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [47:0]        prod_q;
   logic signed [9:0]  exp_q;
   logic               sign_q;
   logic [23:0]        mant_q;
   logic               r_q;
   logic               s_q;

   logic               rnd_inc;
   logic [24:0]        mant_rnd;
   logic               exp_ovf;
   logic               exp_unf;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (REQ) state_d = NORM;
         NORM:    state_d = ROUND;
         ROUND:   state_d = PACK;
         PACK:    state_d = DONE;
         DONE:    if (!REQ) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Ties go to the even mantissa; the 25th bit catches the all-ones carry-out.
   assign rnd_inc  = r_q & (s_q | mant_q[0]);
   assign mant_rnd = {1'b0, mant_q} + {24'd0, rnd_inc};
   assign exp_ovf  = (exp_q >= 10'sd255);
   assign exp_unf  = (exp_q <= 10'sd0);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         prod_q <= '0;
         exp_q  <= '0;
         sign_q <= 1'b0;
         mant_q <= '0;
         r_q    <= 1'b0;
         s_q    <= 1'b0;
         ACK    <= 1'b0;
         Z      <= '0;
         EXC    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (REQ) begin
                  prod_q <= PROD;
                  exp_q  <= EXP_IN;
                  sign_q <= SIGN_IN;
               end
            end
            NORM: begin
               if (prod_q[47]) begin
                  mant_q <= prod_q[47:24];
                  r_q    <= prod_q[23];
                  s_q    <= |prod_q[22:0];
                  exp_q  <= exp_q + 10'sd1;
               end else begin
                  mant_q <= prod_q[46:23];
                  r_q    <= prod_q[22];
                  s_q    <= |prod_q[21:0];
               end
            end
            ROUND: begin
               if (mant_rnd[24]) begin
                  mant_q <= 24'h800000;
                  exp_q  <= exp_q + 10'sd1;
               end else begin
                  mant_q <= mant_rnd[23:0];
               end
            end
            PACK: begin
               ACK <= 1'b1;
               // Zero product outranks the exponent range checks.
               if (prod_q == 48'd0) begin
                  Z   <= {sign_q, 31'd0};
                  EXC <= 3'b000;
               end else if (exp_ovf) begin
                  Z   <= {sign_q, 8'hFF, 23'd0};
                  EXC <= 3'b101;
               end else if (exp_unf) begin
                  Z   <= {sign_q, 31'd0};
                  EXC <= 3'b110;
               end else begin
                  Z   <= {sign_q, exp_q[7:0], mant_q[22:0]};
                  EXC <= {r_q | s_q, 2'b00};
               end
            end
            DONE: begin
               if (!REQ) ACK <= 1'b0;
            end
            default: begin
               ACK <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpmul_norm_round.sv
// Bench for fpmul_norm_round: table of vectors through a scoreboard queue,
// plus handshake-hold, early REQ drop and mid-operation reset sequences.
module tb_fpmul_norm_round;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic        REQ;
   logic [47:0] PROD;
   logic [9:0]  EXP_IN;
   logic        SIGN_IN;
   logic        ACK;
   logic [31:0] Z;
   logic [2:0]  EXC;

   fpmul_norm_round dut (
      .CLK     (CLK),
      .RSTN    (RSTN),
      .REQ     (REQ),
      .PROD    (PROD),
      .EXP_IN  (EXP_IN),
      .SIGN_IN (SIGN_IN),
      .ACK     (ACK),
      .Z       (Z),
      .EXC     (EXC)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic [47:0] prod;
      logic [9:0]  exp;
      logic        sign;
      logic [31:0] z;
      logic [2:0]  exc;
   } vec_t;

   typedef struct packed {
      logic [31:0] z;
      logic [2:0]  exc;
   } res_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];
   res_t sb_q [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Captures one transaction, then scrambles the inputs so any late resampling shows.
   task automatic capture(input logic [47:0] prod, input logic [9:0] exp, input logic sign,
                          input logic [31:0] z, input logic [2:0] exc);
      logic [63:0] rnd;
      @(negedge CLK);
      PROD    = prod;
      EXP_IN  = exp;
      SIGN_IN = sign;
      REQ     = 1'b1;
      sb_q.push_back({z, exc});
      @(posedge CLK);
      #1;
      rnd     = {$urandom(), $urandom()};
      PROD    = rnd[47:0];
      EXP_IN  = rnd[57:48];
      SIGN_IN = ~sign;
   endtask

   task automatic wait_result(input string name);
      int   lat;
      res_t e;
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge CLK);
         #1;
         if (ACK) begin
            lat = c;
            break;
         end
      end
      check({name, "_latency"}, 48'(lat), 48'd3);
      e = '0;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      check({name, "_z"},   48'(Z),   48'(e.z));
      check({name, "_exc"}, 48'(EXC), 48'(e.exc));
   endtask

   task automatic release_req(input string name);
      @(negedge CLK);
      REQ = 1'b0;
      @(posedge CLK);
      #1;
      check({name, "_ack_fall"}, 48'(ACK), 48'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{"mul_2p25",      48'h900000000000, 10'd127, 1'b0, 32'h40100000, 3'b000};
      vecs[1]  = '{"tie_even_down", 48'h400000400000, 10'd127, 1'b0, 32'h3F800000, 3'b100};
      vecs[2]  = '{"tie_even_up",   48'h400000C00000, 10'd127, 1'b0, 32'h3F800002, 3'b100};
      vecs[3]  = '{"round_carry",   48'h7FFFFFC00000, 10'd127, 1'b0, 32'h40000000, 3'b100};
      vecs[4]  = '{"overflow",      48'h800000000000, 10'd254, 1'b0, 32'h7F800000, 3'b101};
      vecs[5]  = '{"underflow_neg", 48'h400000000000, 10'd0,   1'b1, 32'h80000000, 3'b110};
      vecs[6]  = '{"zero_neg",      48'h000000000000, 10'd0,   1'b1, 32'h80000000, 3'b000};
      vecs[7]  = '{"one_neg",       48'h400000000000, 10'd127, 1'b1, 32'hBF800000, 3'b000};
      vecs[8]  = '{"exp_negative",  48'h400000000000, 10'h3FB, 1'b0, 32'h00000000, 3'b110};
      vecs[9]  = '{"exp_max_norm",  48'h400000000000, 10'd254, 1'b0, 32'h7F000000, 3'b000};
      vecs[10] = '{"exp_min_norm",  48'h400000000000, 10'd1,   1'b0, 32'h00800000, 3'b000};
      vecs[11] = '{"carry_to_ovf",  48'h7FFFFFC00000, 10'd254, 1'b0, 32'h7F800000, 3'b101};
      vecs[12] = '{"carry_from_0",  48'h7FFFFFC00000, 10'd0,   1'b0, 32'h00800000, 3'b100};
      vecs[13] = '{"round_r_s",     48'h400000600000, 10'd127, 1'b0, 32'h3F800001, 3'b100};
      vecs[14] = '{"hi_tie_even",   48'h800000800000, 10'd127, 1'b0, 32'h40000000, 3'b100};
      vecs[15] = '{"sticky_only",   48'h400000000001, 10'd127, 1'b0, 32'h3F800000, 3'b100};
      vecs[16] = '{"zero_big_exp",  48'h000000000000, 10'd300, 1'b0, 32'h00000000, 3'b000};

      RSTN    = 1'b0;
      REQ     = 1'b0;
      PROD    = '0;
      EXP_IN  = '0;
      SIGN_IN = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset_ack", 48'(ACK), 48'd0);
      check("reset_z",   48'(Z),   48'd0);
      check("reset_exc", 48'(EXC), 48'd0);
      @(negedge CLK);
      RSTN = 1'b1;

      foreach (vecs[i]) begin
         capture(vecs[i].prod, vecs[i].exp, vecs[i].sign, vecs[i].z, vecs[i].exc);
         wait_result(vecs[i].name);
         release_req(vecs[i].name);
      end

      // REQ held after ACK: result and ACK stay put, nothing is recaptured.
      capture(48'h900000000000, 10'd127, 1'b0, 32'h40100000, 3'b000);
      wait_result("hold");
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         PROD   = {16'h0, $urandom()};
         EXP_IN = 10'd200;
         @(posedge CLK);
         #1;
         check("hold_ack", 48'(ACK), 48'd1);
         check("hold_z",   48'(Z),   48'h40100000);
      end
      release_req("hold");
      repeat (3) begin
         @(posedge CLK);
         #1;
         check("hold_no_recapture", 48'(ACK), 48'd0);
      end

      // REQ dropped right after capture: result still completes, ACK lasts one cycle.
      capture(48'h400000C00000, 10'd127, 1'b1, 32'hBF800002, 3'b100);
      REQ = 1'b0;
      wait_result("early_drop");
      @(posedge CLK);
      #1;
      check("early_drop_ack_fall", 48'(ACK), 48'd0);

      // Reset asserted while in ROUND clears outputs at once and discards the transaction.
      capture(48'h7FFFFFC00000, 10'd127, 1'b0, 32'h40000000, 3'b100);
      void'(sb_q.pop_front());
      @(posedge CLK);
      #2;
      RSTN = 1'b0;
      #1;
      check("midrst_ack", 48'(ACK), 48'd0);
      check("midrst_z",   48'(Z),   48'd0);
      check("midrst_exc", 48'(EXC), 48'd0);
      REQ = 1'b0;
      @(negedge CLK);
      RSTN = 1'b1;
      repeat (5) begin
         @(posedge CLK);
         #1;
         check("midrst_discarded", 48'(ACK), 48'd0);
      end
      capture(48'h900000000000, 10'd127, 1'b0, 32'h40100000, 3'b000);
      wait_result("after_rst");
      release_req("after_rst");

      check("scoreboard_empty", 48'(sb_q.size()), 48'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
